// File: rtl/multi_delay_gen_pkg.sv
// Shared types and default constants for the multi-channel delay generator.
// Each channel waits a programmable number of timebase ticks before gating its enable.
package multi_delay_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } chan_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/delay_chan.sv
// One delay channel: latches its delay on leaving IDLE, counts ticks, then gates enable.
//   state | meaning
//   IDLE  | waiting to start; one-shot starts at once, retrigger waits for enable_i
//   COUNT | counting ticks up to the latched delay
//   DONE  | delay elapsed; enable_o follows enable_i one cycle late
module delay_chan
  import multi_delay_gen_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter bit RETRIG = 1'b0
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             tick_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic             enable_i,
  output logic             enable_o,
  output logic             done_o
);

  chan_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] cnt_nxt;
  logic             start;
  logic             drop;

  assign cnt_nxt = cnt + 1'b1;
  assign start   = RETRIG ? enable_i : 1'b1;
  // Retrigger channels abandon progress as soon as the request goes away.
  assign drop    = RETRIG && !enable_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      dly      <= '0;
      enable_o <= 1'b0;
    end else if (clear_i) begin
      state    <= IDLE;
      cnt      <= '0;
      dly      <= '0;
      enable_o <= 1'b0;
    end else begin
      enable_o <= enable_i && (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            dly   <= delay_i;
            cnt   <= '0;
            state <= (delay_i == '0) ? DONE : COUNT;
          end
        end
        COUNT: begin
          if (drop) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tick_i) begin
            // cnt stays below dly here, so the increment cannot wrap.
            cnt <= cnt_nxt;
            if (cnt_nxt == dly) state <= DONE;
          end
        end
        DONE: begin
          if (drop) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign done_o = (state == DONE);

endmodule

// File: rtl/multi_delay_gen.sv
// Array of independent delay channels sharing one timebase tick and a global clear.
// Bit g of RETRIG_MASK selects retrigger (1) or one-shot (0) behaviour for channel g.
module multi_delay_gen
  import multi_delay_gen_pkg::*;
#(
  parameter int                NUM_CH      = DEF_NUM_CH,
  parameter int                CNT_W       = DEF_CNT_W,
  parameter logic [NUM_CH-1:0] RETRIG_MASK = '0
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    tick_i,
  input  logic                    clear_i,
  input  logic [NUM_CH*CNT_W-1:0] delay_i,
  input  logic [NUM_CH-1:0]       enable_i,
  output logic [NUM_CH-1:0]       enable_o,
  output logic [NUM_CH-1:0]       done_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    delay_chan #(
      .CNT_W  (CNT_W),
      .RETRIG (RETRIG_MASK[g])
    ) u_chan (
      .clk_i    (clk_i),
      .arst_ni  (arst_ni),
      .tick_i   (tick_i),
      .clear_i  (clear_i),
      .delay_i  (delay_i[g*CNT_W +: CNT_W]),
      .enable_i (enable_i[g]),
      .enable_o (enable_o[g]),
      .done_o   (done_o[g])
    );
  end

endmodule

// File: tb/tb_multi_delay_gen.sv
// Directed bench for multi_delay_gen: 4 channels, 8-bit delays, channels 1 and 3 retrigger.
// Ticks are issued as one strobe cycle followed by nine quiet cycles.
module tb_multi_delay_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk_i = 1'b0;
  logic                    arst_ni;
  logic                    tick_i;
  logic                    clear_i;
  logic [NUM_CH*CNT_W-1:0] delay_i;
  logic [NUM_CH-1:0]       enable_i;
  logic [NUM_CH-1:0]       enable_o;
  logic [NUM_CH-1:0]       done_o;

  int tests = 0;
  int fails = 0;

  multi_delay_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .RETRIG_MASK (4'b1010)
  ) dut (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .tick_i   (tick_i),
    .clear_i  (clear_i),
    .delay_i  (delay_i),
    .enable_i (enable_i),
    .enable_o (enable_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic edge1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) edge1();
  endtask

  task automatic tick_edge();
    tick_i = 1'b1;
    edge1();
    tick_i = 1'b0;
  endtask

  task automatic test_reset();
    arst_ni  = 1'b0;
    tick_i   = 1'b0;
    clear_i  = 1'b0;
    enable_i = 4'b0101;
    delay_i  = {8'd2, 8'd0, 8'd3, 8'd5};
    #2;
    tests++;
    if (done_o !== 4'b0000 || enable_o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_state: done=%b en=%b want 0000/0000", done_o, enable_o);
    end
    idle(3);
    arst_ni = 1'b1;
    edge1();
    tests++;
    if (done_o !== 4'b0100 || enable_o !== 4'b0000) begin
      fails++;
      $display("FAIL zero_delay_entry: done=%b en=%b want 0100/0000", done_o, enable_o);
    end
    edge1();
    tests++;
    if (enable_o !== 4'b0100) begin
      fails++;
      $display("FAIL zero_delay_enable: en=%b want 0100", enable_o);
    end
  endtask

  task automatic test_one_shot();
    for (int t = 1; t <= 4; t++) begin
      tick_edge();
      tests++;
      if (done_o[0] !== 1'b0 || enable_o[0] !== 1'b0) begin
        fails++;
        $display("FAIL one_shot_early tick=%0d: done=%b en=%b want 0/0", t, done_o[0], enable_o[0]);
      end
      idle(9);
    end
    tick_edge();
    tests++;
    if (done_o !== 4'b0101 || enable_o[0] !== 1'b0) begin
      fails++;
      $display("FAIL one_shot_done: done=%b en0=%b want 0101/0", done_o, enable_o[0]);
    end
    edge1();
    tests++;
    if (enable_o !== 4'b0101) begin
      fails++;
      $display("FAIL one_shot_enable: en=%b want 0101", enable_o);
    end
    enable_i[0] = 1'b0;
    edge1();
    tests++;
    if (enable_o[0] !== 1'b0 || done_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL one_shot_terminal: en0=%b done0=%b want 0/1", enable_o[0], done_o[0]);
    end
    enable_i[0] = 1'b1;
    edge1();
    tests++;
    if (enable_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL one_shot_follow: en0=%b want 1", enable_o[0]);
    end
    idle(8);
  endtask

  task automatic run_ch1_three_ticks(input string tag);
    for (int t = 1; t <= 2; t++) begin
      tick_edge();
      tests++;
      if (done_o[1] !== 1'b0) begin
        fails++;
        $display("FAIL %s_early tick=%0d: done1=%b want 0", tag, t, done_o[1]);
      end
      idle(9);
    end
    tick_edge();
    tests++;
    if (done_o !== 4'b0111) begin
      fails++;
      $display("FAIL %s_done: done=%b want 0111", tag, done_o);
    end
    edge1();
    tests++;
    if (enable_o !== 4'b0111) begin
      fails++;
      $display("FAIL %s_enable: en=%b want 0111", tag, enable_o);
    end
  endtask

  task automatic test_retrigger();
    enable_i[1] = 1'b1;
    edge1();
    tests++;
    if (done_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL retrig_start: done1=%b want 0", done_o[1]);
    end
    idle(5);
    run_ch1_three_ticks("retrig_first");
    enable_i[1] = 1'b0;
    edge1();
    tests++;
    if (done_o !== 4'b0101 || enable_o !== 4'b0101) begin
      fails++;
      $display("FAIL retrig_drop: done=%b en=%b want 0101/0101", done_o, enable_o);
    end
    enable_i[1] = 1'b1;
    edge1();
    idle(5);
    run_ch1_three_ticks("retrig_again");
    enable_i[1] = 1'b0;
    idle(3);
  endtask

  task automatic test_clear();
    clear_i = 1'b1;
    edge1();
    clear_i = 1'b0;
    tests++;
    if (done_o !== 4'b0000 || enable_o !== 4'b0000) begin
      fails++;
      $display("FAIL clear_all: done=%b en=%b want 0000/0000", done_o, enable_o);
    end
    edge1();
    tests++;
    if (done_o !== 4'b0100) begin
      fails++;
      $display("FAIL clear_restart: done=%b want 0100", done_o);
    end
    idle(5);
    tick_edge(); idle(9);
    tick_edge(); idle(9);
    tick_i  = 1'b1;
    clear_i = 1'b1;
    edge1();
    tick_i  = 1'b0;
    clear_i = 1'b0;
    tests++;
    if (done_o !== 4'b0000 || enable_o !== 4'b0000) begin
      fails++;
      $display("FAIL clear_vs_tick: done=%b en=%b want 0000/0000", done_o, enable_o);
    end
    edge1();
    idle(5);
    for (int t = 1; t <= 4; t++) begin
      tick_edge();
      tests++;
      if (done_o[0] !== 1'b0) begin
        fails++;
        $display("FAIL clear_full_count tick=%0d: done0=%b want 0", t, done_o[0]);
      end
      idle(9);
    end
    tick_edge();
    tests++;
    if (done_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL clear_full_done: done0=%b want 1", done_o[0]);
    end
    idle(9);
    clear_i = 1'b1;
    edge1();
    clear_i = 1'b0;
    edge1();
    idle(5);
    tick_edge();
    delay_i[7:0] = 8'd2;
    idle(9);
    for (int t = 2; t <= 4; t++) begin
      tick_edge();
      tests++;
      if (done_o[0] !== 1'b0) begin
        fails++;
        $display("FAIL delay_change tick=%0d: done0=%b want 0", t, done_o[0]);
      end
      idle(9);
    end
    tick_edge();
    tests++;
    if (done_o[0] !== 1'b1) begin
      fails++;
      $display("FAIL delay_change_done: done0=%b want 1", done_o[0]);
    end
    delay_i[7:0] = 8'd5;
    idle(9);
  endtask

  task automatic test_async_reset();
    clear_i = 1'b1;
    edge1();
    clear_i = 1'b0;
    edge1();
    idle(5);
    tick_edge(); idle(9);
    tick_edge(); idle(4);
    arst_ni = 1'b0;
    #1;
    tests++;
    if (done_o !== 4'b0000 || enable_o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_count: done=%b en=%b want 0000/0000", done_o, enable_o);
    end
    idle(2);
    arst_ni = 1'b1;
    edge1();
    idle(5);
    for (int t = 1; t <= 4; t++) begin
      tick_edge();
      tests++;
      if (done_o[0] !== 1'b0) begin
        fails++;
        $display("FAIL reset_full_count tick=%0d: done0=%b want 0", t, done_o[0]);
      end
      idle(9);
    end
    tick_edge();
    edge1();
    tests++;
    if (done_o !== 4'b0101 || enable_o !== 4'b0101) begin
      fails++;
      $display("FAIL reset_redone: done=%b en=%b want 0101/0101", done_o, enable_o);
    end
    #2;
    arst_ni = 1'b0;
    #1;
    tests++;
    if (done_o !== 4'b0000 || enable_o !== 4'b0000) begin
      fails++;
      $display("FAIL reset_in_done: done=%b en=%b want 0000/0000", done_o, enable_o);
    end
    idle(2);
    arst_ni = 1'b1;
    edge1();
    tests++;
    if (done_o !== 4'b0100) begin
      fails++;
      $display("FAIL reset_release: done=%b want 0100", done_o);
    end
  endtask

  initial begin
    test_reset();
    idle(4);
    test_one_shot();
    test_retrigger();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
